// File: rtl/sevseg_pkg.sv
// Shared constants for the four-digit seven-segment scan driver:
// display code values, the code-to-segment pattern table and the
// default refresh divider.
package sevseg_pkg;

  localparam int REFRESH_DIV_DEFAULT = 100000;

  localparam logic [3:0] CODE_ZERO  = 4'd0;
  localparam logic [3:0] CODE_MINUS = 4'd10;
  localparam logic [3:0] CODE_BLANK = 4'd11;
  localparam logic [3:0] CODE_ERR   = 4'd12;

  // Active-low {g,f,e,d,c,b,a}; entry 15 first, entry 0 last.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h7F, // 15 blank
    7'h7F, // 14 blank
    7'h7F, // 13 blank
    7'h06, // 12 "E"
    7'h7F, // 11 blank
    7'h3F, // 10 minus
    7'h10, // 9
    7'h00, // 8
    7'h78, // 7
    7'h02, // 6
    7'h12, // 5
    7'h19, // 4
    7'h30, // 3
    7'h24, // 2
    7'h79, // 1
    7'h40  // 0
  };

endpackage

// File: rtl/sevseg_decoder.sv
// Combinational 4-bit display code to active-low 7-segment pattern.
module sevseg_decoder
  import sevseg_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] pattern
);

  // Table lookup; every code 0..15 has a defined entry.
  always_comb begin
    pattern = SEG_TABLE[code];
  end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Multiplexed four-digit seven-segment driver. A prescaler sets how long
// each digit stays lit; digit values are latched into shadow registers
// once per frame so the display never shows a torn frame.
// Optional feature macro: SEVSEG_LZB_EN (leading-zero blanking on
// digit1..digit3 when the decimal point is off).
module seven_seg_scan_driver
  import sevseg_pkg::*;
#(
  parameter int REFRESH_DIV = REFRESH_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] digit1,
  input  logic [3:0] digit2,
  input  logic [3:0] digit3,
  input  logic [3:0] digit4,
  input  logic       showPoint,
  output logic [7:0] ss,
  output logic [3:0] enables,
  output logic       frame_strobe
);

  localparam int              CW       = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0]   CNT_LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic          first;
  logic          tick;
  logic          capture;

  logic [3:0]    sh_d1;
  logic [3:0]    sh_d2;
  logic [3:0]    sh_d3;
  logic [3:0]    sh_d4;
  logic          sh_point;

  logic [3:0]    cur_code;
  logic [3:0]    shown_code;
  logic [6:0]    pattern;
  logic          dp;
  logic [3:0]    en_next;

  assign tick    = (cnt == CNT_LAST);
  // "first" is high only on the first cycle out of reset, forcing an
  // immediate capture so the display does not wait a whole frame.
  assign capture = first | (tick & (idx == 2'd3));

  // Prescaler, scan index and first-cycle flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      idx   <= 2'd0;
      first <= 1'b1;
    end else begin
      first <= 1'b0;
      if (tick) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Shadow copy of the digit inputs, refreshed once per frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_d1    <= CODE_BLANK;
      sh_d2    <= CODE_BLANK;
      sh_d3    <= CODE_BLANK;
      sh_d4    <= CODE_BLANK;
      sh_point <= 1'b0;
    end else if (capture) begin
      sh_d1    <= digit1;
      sh_d2    <= digit2;
      sh_d3    <= digit3;
      sh_d4    <= digit4;
      sh_point <= showPoint;
    end else begin
      sh_d1    <= sh_d1;
      sh_d2    <= sh_d2;
      sh_d3    <= sh_d3;
      sh_d4    <= sh_d4;
      sh_point <= sh_point;
    end
  end

  // Pulse one cycle after each shadow capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_strobe <= 1'b0;
    end else begin
      frame_strobe <= capture;
    end
  end

  // Select the active digit code and its anode pattern.
  always_comb begin
    cur_code = sh_d1;
    en_next  = 4'b0111;
    case (idx)
      2'd0: begin
        cur_code = sh_d1;
        en_next  = 4'b0111;
      end
      2'd1: begin
        cur_code = sh_d2;
        en_next  = 4'b1011;
      end
      2'd2: begin
        cur_code = sh_d3;
        en_next  = 4'b1101;
      end
      2'd3: begin
        cur_code = sh_d4;
        en_next  = 4'b1110;
      end
      default: begin
        cur_code = sh_d1;
        en_next  = 4'b0111;
      end
    endcase
  end

`ifdef SEVSEG_LZB_EN
  logic [2:0] lead_zero;

  // Leading-zero run from the left; suppressed when the point is shown.
  always_comb begin
    lead_zero[0] = ~sh_point & (sh_d1 == CODE_ZERO);
    lead_zero[1] = lead_zero[0] & (sh_d2 == CODE_ZERO);
    lead_zero[2] = lead_zero[1] & (sh_d3 == CODE_ZERO);
  end

  // Replace a leading zero with blank; digit4 always shows its code.
  always_comb begin
    shown_code = cur_code;
    case (idx)
      2'd0:    shown_code = lead_zero[0] ? CODE_BLANK : cur_code;
      2'd1:    shown_code = lead_zero[1] ? CODE_BLANK : cur_code;
      2'd2:    shown_code = lead_zero[2] ? CODE_BLANK : cur_code;
      default: shown_code = cur_code;
    endcase
  end
`else
  // Codes are displayed unmodified.
  always_comb begin
    shown_code = cur_code;
  end
`endif

  sevseg_decoder u_decoder (
    .code    (shown_code),
    .pattern (pattern)
  );

  // Decimal point lives only on the digit2 position.
  always_comb begin
    dp = ~((idx == 2'd1) & sh_point);
  end

  // Registered display outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      ss      <= 8'hFF;
      enables <= 4'hF;
    end else begin
      ss      <= {dp, pattern};
      enables <= en_next;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed, table-driven bench for seven_seg_scan_driver with
// REFRESH_DIV=4. Build with SEVSEG_LZB_EN defined to exercise the
// leading-zero-blanking expectations.
module tb_seven_seg_scan_driver;

  logic       clk;
  logic       reset;
  logic [3:0] digit1;
  logic [3:0] digit2;
  logic [3:0] digit3;
  logic [3:0] digit4;
  logic       showPoint;
  logic [7:0] ss;
  logic [3:0] enables;
  logic       frame_strobe;

  int n_checks;
  int n_fail;

  typedef struct {
    logic [3:0] d1, d2, d3, d4;
    logic       pt;
    logic [7:0] e1, e2, e3, e4;
  } vec_t;

  vec_t vecs [7];

  seven_seg_scan_driver #(.REFRESH_DIV(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .digit1       (digit1),
    .digit2       (digit2),
    .digit3       (digit3),
    .digit4       (digit4),
    .showPoint    (showPoint),
    .ss           (ss),
    .enables      (enables),
    .frame_strobe (frame_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_digits(input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] c, input logic [3:0] d, input logic p);
    digit1 = a; digit2 = b; digit3 = c; digit4 = d; showPoint = p;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) step();
    reset = 1'b0;
  endtask

  function automatic logic [7:0] pick(input vec_t v, input int pos);
    case (pos)
      0: return v.e1;
      1: return v.e2;
      2: return v.e3;
      default: return v.e4;
    endcase
  endfunction

  function automatic logic [3:0] en_of(input int pos);
    case (pos)
      0: return 4'b0111;
      1: return 4'b1011;
      2: return 4'b1101;
      default: return 4'b1110;
    endcase
  endfunction

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    set_digits(4'd1, 4'd2, 4'd3, 4'd4, 1'b0);

    vecs[0] = '{4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 8'hF9, 8'hA4, 8'hB0, 8'h99};
    vecs[1] = '{4'd10, 4'd12, 4'd11, 4'd5, 1'b1, 8'hBF, 8'h06, 8'hFF, 8'h92};
    vecs[2] = '{4'd6, 4'd7, 4'd8, 4'd9, 1'b0, 8'h82, 8'hF8, 8'h80, 8'h90};
`ifdef SEVSEG_LZB_EN
    vecs[3] = '{4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 8'hFF, 8'hFF, 8'hFF, 8'hC0};
    vecs[5] = '{4'd0, 4'd0, 4'd7, 4'd0, 1'b0, 8'hFF, 8'hFF, 8'hF8, 8'hC0};
`else
    vecs[3] = '{4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
    vecs[5] = '{4'd0, 4'd0, 4'd7, 4'd0, 1'b0, 8'hC0, 8'hC0, 8'hF8, 8'hC0};
`endif
    vecs[4] = '{4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 8'hC0, 8'h40, 8'hC0, 8'hC0};
    vecs[6] = '{4'd13, 4'd14, 4'd15, 4'd0, 1'b0, 8'hFF, 8'hFF, 8'hFF, 8'hC0};

    // Reset held for three cycles: outputs idle on every cycle.
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_ss", ss, 8'hFF);
      check("rst_en", {4'h0, enables}, 8'h0F);
      check("rst_fs", {7'h0, frame_strobe}, 8'h00);
    end

    // Table: one full frame per vector, starting from reset.
    for (int v = 0; v < 7; v++) begin
      set_digits(vecs[v].d1, vecs[v].d2, vecs[v].d3, vecs[v].d4, vecs[v].pt);
      do_reset(2);
      for (int cyc = 1; cyc <= 16; cyc++) begin
        int pos;
        step();
        pos = (cyc - 1) / 4;
        check($sformatf("v%0d_c%0d_en", v, cyc), {4'h0, enables}, {4'h0, en_of(pos)});
        check($sformatf("v%0d_c%0d_ss", v, cyc), ss, (cyc == 1) ? 8'hFF : pick(vecs[v], pos));
        check($sformatf("v%0d_c%0d_fs", v, cyc), {7'h0, frame_strobe},
              (cyc == 1 || cyc == 16) ? 8'h01 : 8'h00);
      end
    end

    // Shadow: digit4 changes 4 -> 9 while index 1 is showing.
    set_digits(4'd1, 4'd2, 4'd3, 4'd4, 1'b0);
    do_reset(2);
    for (int cyc = 1; cyc <= 32; cyc++) begin
      step();
      if (cyc == 5) digit4 = 4'd9;
      if (cyc >= 13 && cyc <= 16) check($sformatf("shadow_old_c%0d", cyc), ss, 8'h99);
      if (cyc == 16) check("shadow_fs", {7'h0, frame_strobe}, 8'h01);
      if (cyc >= 17 && cyc <= 20) check($sformatf("shadow_d1_c%0d", cyc), ss, 8'hF9);
      if (cyc >= 29) check($sformatf("shadow_new_c%0d", cyc), ss, 8'h90);
    end

    // Reset mid-scan at index 2, then restart from digit1.
    do_reset(2);
    for (int cyc = 1; cyc <= 10; cyc++) step();
    check("mid_pre_en", {4'h0, enables}, 8'h0D);
    reset = 1'b1;
    step();
    check("mid_rst_ss", ss, 8'hFF);
    check("mid_rst_en", {4'h0, enables}, 8'h0F);
    check("mid_rst_fs", {7'h0, frame_strobe}, 8'h00);
    reset = 1'b0;
    step();
    check("mid_rel_en", {4'h0, enables}, 8'h07);
    check("mid_rel_fs", {7'h0, frame_strobe}, 8'h01);
    step();
    check("mid_rel_ss", ss, 8'hF9);
    check("mid_rel_en2", {4'h0, enables}, 8'h07);
    check("mid_rel_fs2", {7'h0, frame_strobe}, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_driver.md
SEVEN_SEG_SCAN_DRIVER -- requirements
Module: seven_seg_scan_driver

Interface
REQ-001 The block SHALL have parameter REFRESH_DIV, default 100000, giving the clk cycles each digit stays lit; legal range 2..2^20.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-004 The block SHALL have ports digit1..digit4, each input, 4 bits, display codes; digit1 is the leftmost position and digit4 the rightmost.
REQ-005 The block SHALL have port showPoint, input, 1 bit; when it is 1, the decimal point is lit on the digit2 position.
REQ-006 The block SHALL have port ss, output, 8 bits; ss[6:0] is {g,f,e,d,c,b,a} and ss[7] is dp, all active-low.
REQ-007 The block SHALL have port enables, output, 4 bits, active-low anodes; enables[3] is digit1 and enables[0] is digit4.
REQ-008 The block SHALL have port frame_strobe, output, 1 bit, a one-cycle pulse when a new digit set is latched.

Function
REQ-009 The block SHALL decode codes as follows: 0-9 are decimal glyphs; 10 is minus (ss[6:0]=7'h3F); 11 is blank (7'h7F); 12 is "E" (7'h06); 13-15 are blank.
REQ-010 The block SHALL use these glyph patterns: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 (hex, ss[6:0]).
REQ-011 A prescaler SHALL count 0..REFRESH_DIV-1 and wrap to 0; tick is asserted on the cycle the count equals REFRESH_DIV-1.
REQ-012 A 2-bit scan index SHALL advance 0->1->2->3->0 on each tick; index 0 selects digit1 and index 3 selects digit4.
REQ-013 A shadow register set (digit1..4, showPoint) SHALL capture the inputs on the cycle where tick is high and index is 3, and on the first cycle after reset deasserts.
REQ-014 frame_strobe SHALL be high for exactly the one cycle following each shadow capture.
REQ-015 Input changes between captures SHALL NOT affect the display until the next frame.
REQ-016 ss and enables SHALL be registered; they reflect the current index and shadow registers one cycle after an index change.
REQ-017 Exactly one enables bit SHALL be low at any time outside reset.
REQ-018 ss[7] SHALL be 0 only when the active index is 1 and the shadow showPoint is 1; otherwise it is 1.
REQ-019 At the index 3->0 wrap, the index-0 digit SHALL be decoded from the newly captured shadow values.

Reset
REQ-020 While reset=1: ss=8'hFF, enables=4'hF, frame_strobe=0, prescaler=0, index=0, shadow digits=11 (blank), shadow showPoint=0.
REQ-021 When reset is asserted mid-scan, all state SHALL return to reset values on the next edge, and no partial frame is completed.
REQ-022 After reset deasserts, the first capture and frame_strobe SHALL occur per REQ-013/014, and digit1 SHALL be lit from the second cycle after deassertion.

Configuration
REQ-023 Macro SEVSEG_LZB_EN defined: when shadow showPoint=0, leading code-0 digits in positions digit1..digit3 SHALL display blank, scanning left to right until the first nonzero code; digit4 is never blanked.
REQ-024 Macro SEVSEG_LZB_EN undefined: code 0 SHALL always display "0".
REQ-025 With SEVSEG_LZB_EN defined, the block SHALL NOT blank any digit when shadow showPoint=1.

Structure
REQ-026 Package sevseg_pkg SHALL hold the code constants (CODE_MINUS=10, CODE_BLANK=11, CODE_ERR=12), the 16-entry segment pattern table, and the REFRESH_DIV default.
REQ-027 The design SHALL contain one combinational sub-module, sevseg_decoder (4-bit code -> 7-bit pattern), instantiated once on the muxed digit.
REQ-028 The prescaler width SHALL be $clog2(REFRESH_DIV).

Verification (REFRESH_DIV=4)
REQ-029 The bench SHALL check reset: hold reset 3 cycles -> ss=FF, enables=F, frame_strobe=0 on every cycle.
REQ-030 The bench SHALL check scan order: digits 1,2,3,4 with showPoint=0 -> enables cycles E(sic 4'b0111) "1", 1011 "2", 1101 "3", 1110 "4", each 4 cycles, with ss[7]=1 throughout.
REQ-031 The bench SHALL check point and special codes: digits 10,12,11,5 with showPoint=1 -> patterns 3F, 06 with dp=0, 7F, 12.
REQ-032 The bench SHALL check the shadow: change digit4 from 4 to 9 while index=1 -> digit4 still shows 19(hex "4") this frame and 10 ("9") after the next frame_strobe.
REQ-033 The bench SHALL check reset mid-scan: assert reset at index 2 -> next cycle ss=FF, enables=F, and after release the scan restarts at digit1.
REQ-034 The bench SHALL check LZB (SEVSEG_LZB_EN defined): digits 0,0,0,0 with showPoint=0 -> only digit4 shows "0"; digits 0,0,0,0 with showPoint=1 -> all four show "0".
